// File: rtl/key_press_conditioner.sv
// key_press_conditioner: turns two raw active-low push-buttons into one-cycle
// press pulses for the game core. Each channel has a two-flop synchronizer and
// a four-state debounce FSM with an 8-bit stability counter.
// Optional build macro CPU_OPPONENT_EN adds an LFSR-driven computer opponent
// that can take over the right channel when cpuEnable is high.
module key_press_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       LeftKEY,
   input  logic       RightKEY,
   input  logic       cpuEnable,
   input  logic [3:0] cpuSpeed,
   output logic       LeftButton,
   output logic       RightButton
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Counter value on the last of the required stable cycles.
   localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

   logic [1:0] raw_key;
   logic [1:0] force_idle;
   logic [1:0] press_accept;
   logic       left_button_reg;
   logic       right_button_reg;
   logic       right_button_next;

   // Index 0 is the left player, index 1 the right player.
   assign raw_key = {RightKEY, LeftKEY};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_channel
         logic       sync_meta_reg;
         logic       sync_reg;
         logic       pressed;
         state_t     state_reg;
         state_t     state_next;
         logic [7:0] count_reg;
         logic [7:0] count_next;
         logic       accept_next;

         // Two-flop synchronizer; resets to the released level.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               sync_meta_reg <= 1'b1;
               sync_reg      <= 1'b1;
            end else begin
               sync_meta_reg <= raw_key[gi];
               sync_reg      <= sync_meta_reg;
            end
         end

         assign pressed = ~sync_reg;

         // Debounce state and stability counter.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               state_reg <= IDLE;
               count_reg <= 8'd0;
            end else begin
               state_reg <= state_next;
               count_reg <= count_next;
            end
         end

         // Next state, counter and press acceptance for this channel.
         always_comb begin
            state_next  = state_reg;
            count_next  = count_reg;
            accept_next = 1'b0;
            if (force_idle[gi]) begin
               state_next = IDLE;
               count_next = 8'd0;
            end else begin
               case (state_reg)
                  IDLE: begin
                     if (pressed) begin
                        state_next = PRESS_WAIT;
                        count_next = 8'd0;
                     end
                  end
                  PRESS_WAIT: begin
                     if (!pressed) begin
                        state_next = IDLE;
                        count_next = 8'd0;
                     end else if (count_reg == LAST_COUNT) begin
                        state_next  = HELD;
                        count_next  = 8'd0;
                        accept_next = 1'b1;
                     end else begin
                        count_next = count_reg + 8'd1;
                     end
                  end
                  HELD: begin
                     if (!pressed) begin
                        state_next = RELEASE_WAIT;
                        count_next = 8'd0;
                     end
                  end
                  RELEASE_WAIT: begin
                     if (pressed) begin
                        // Release bounce: back to held without a new pulse.
                        state_next = HELD;
                        count_next = 8'd0;
                     end else if (count_reg == LAST_COUNT) begin
                        state_next = IDLE;
                        count_next = 8'd0;
                     end else begin
                        count_next = count_reg + 8'd1;
                     end
                  end
                  default: begin
                     state_next = IDLE;
                     count_next = 8'd0;
                  end
               endcase
            end
         end

         assign press_accept[gi] = accept_next;
      end
   endgenerate

`ifdef CPU_OPPONENT_EN
   logic [9:0] lfsr_reg;
   logic       cpu_fire;

   // Free-running 10-bit Fibonacci LFSR, taps 10 and 7.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lfsr_reg <= 10'h001;
      end else begin
         lfsr_reg <= {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
      end
   end

   // Higher cpuSpeed widens the firing window; the previous-cycle check keeps
   // computer presses from landing on adjacent cycles.
   assign cpu_fire          = (lfsr_reg < {cpuSpeed, 6'b0}) && !right_button_reg;
   assign force_idle        = {cpuEnable, 1'b0};
   assign right_button_next = cpuEnable ? cpu_fire : press_accept[1];
`else
   // Opponent controls exist on the port list but have no function here.
   logic unused_cfg;
   assign unused_cfg        = ^{cpuEnable, cpuSpeed};
   assign force_idle        = 2'b00;
   assign right_button_next = press_accept[1];
`endif

   // Registered one-cycle press pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         left_button_reg  <= 1'b0;
         right_button_reg <= 1'b0;
      end else begin
         left_button_reg  <= press_accept[0];
         right_button_reg <= right_button_next;
      end
   end

   assign LeftButton  = left_button_reg;
   assign RightButton = right_button_reg;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Testbench for key_press_conditioner (DEBOUNCE_CYCLES=4): directed scenarios
// followed by randomized key bouncing, checked every cycle against a
// run-length reference model of the debounce rules.
module tb_key_press_conditioner;
   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       LeftKEY;
   logic       RightKEY;
   logic       cpuEnable;
   logic [3:0] cpuSpeed;
   logic       LeftButton;
   logic       RightButton;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   key_press_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clock      (clock),
      .reset      (reset),
      .LeftKEY    (LeftKEY),
      .RightKEY   (RightKEY),
      .cpuEnable  (cpuEnable),
      .cpuSpeed   (cpuSpeed),
      .LeftButton (LeftButton),
      .RightButton(RightButton)
   );

   // Reference model: synchronizer delay line plus, per channel, the length of
   // the current run of identical "pressed" samples and whether a press has
   // been accepted and not yet released. A press is accepted on the (D+1)th
   // consecutive pressed sample while released; a release is accepted on the
   // (D+1)th consecutive released sample while held.
   bit m_s1[2];
   bit m_s2[2];
   bit m_prev[2];
   int m_run[2];
   bit m_held[2];
   bit exp_out[2];
   int m_lfsr;
   int edge_count;

   // Scenario bookkeeping.
   bit last_left, last_right;
   int left_pulses, right_pulses;
   int first_left_edge, first_right_edge;
   bit pair_ok;

   task automatic model_reset();
      for (int ch = 0; ch < 2; ch++) begin
         m_s1[ch]    = 1'b1;
         m_s2[ch]    = 1'b1;
         m_prev[ch]  = 1'b0;
         m_run[ch]   = 0;
         m_held[ch]  = 1'b0;
         exp_out[ch] = 1'b0;
      end
      m_lfsr     = 1;
      edge_count = 0;
   endtask

   task automatic model_edge();
      bit key[2];
      bit p;
      bit prev_right;
      bit cpu_active;
      key[0]     = LeftKEY;
      key[1]     = RightKEY;
      prev_right = exp_out[1];
`ifdef CPU_OPPONENT_EN
      cpu_active = cpuEnable;
`else
      cpu_active = 1'b0;
`endif
      for (int ch = 0; ch < 2; ch++) begin
         p          = !m_s2[ch];
         m_s2[ch]   = m_s1[ch];
         m_s1[ch]   = key[ch];
         exp_out[ch] = 1'b0;
         if (ch == 1 && cpu_active) begin
            m_held[ch] = 1'b0;
            m_run[ch]  = 0;
            m_prev[ch] = 1'b0;
         end else begin
            if (p == m_prev[ch]) m_run[ch]++;
            else m_run[ch] = 1;
            m_prev[ch] = p;
            if (!m_held[ch] && p && m_run[ch] == D + 1) begin
               exp_out[ch] = 1'b1;
               m_held[ch]  = 1'b1;
            end else if (m_held[ch] && !p && m_run[ch] == D + 1) begin
               m_held[ch] = 1'b0;
            end
         end
      end
      if (cpu_active)
         exp_out[1] = (m_lfsr < int'(cpuSpeed) * 64) && !prev_right;
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1)) & 10'h3ff;
   endtask

   task automatic check(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b (edge %0d)", tag, observed, expected, edge_count);
      end
   endtask

   task automatic check_int(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clock cycle: model advances on the edge, outputs compared at negedge.
   task automatic step();
      @(posedge clock);
      if (reset) model_reset();
      else begin
         model_edge();
         edge_count++;
      end
      @(negedge clock);
      check("left_pulse", LeftButton, exp_out[0]);
      check("right_pulse", RightButton, exp_out[1]);
      check("left_not_adjacent", LeftButton && last_left, 1'b0);
      check("right_not_adjacent", RightButton && last_right, 1'b0);
      if (LeftButton) begin
         left_pulses++;
         if (first_left_edge < 0) first_left_edge = edge_count;
      end
      if (RightButton) begin
         right_pulses++;
         if (first_right_edge < 0) first_right_edge = edge_count;
      end
      if (LeftButton !== RightButton) pair_ok = 1'b0;
      last_left  = LeftButton;
      last_right = RightButton;
   endtask

   task automatic clear_stats();
      left_pulses      = 0;
      right_pulses     = 0;
      first_left_edge  = -1;
      first_right_edge = -1;
      pair_ok          = 1'b1;
   endtask

   // Asynchronous reset asserted between edges, held across `edges` edges.
   task automatic apply_reset(input int edges);
      reset = 1'b1;
      #1;
      model_reset();
      check("reset_left", LeftButton, 1'b0);
      check("reset_right", RightButton, 1'b0);
      for (int i = 0; i < edges; i++) step();
      reset = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int hold_l, hold_r;
      reset     = 1'b0;
      LeftKEY   = 1'b1;
      RightKEY  = 1'b1;
      cpuEnable = 1'b0;
      cpuSpeed  = 4'd0;
      last_left = 1'b0;
      last_right = 1'b0;
      model_reset();
      clear_stats();
      @(negedge clock);
      apply_reset(2);

      // Single press: low before edge 10, held 40 cycles.
      clear_stats();
      steps(9);
      LeftKEY = 1'b0;
      steps(40);
      check_int("single_press_edge", first_left_edge, 10 + 2 + D);
      check_int("single_press_count", left_pulses, 1);
      check_int("single_press_right_quiet", right_pulses, 0);
      LeftKEY = 1'b1;
      steps(12);

      // Short bounce never reaches acceptance.
      clear_stats();
      LeftKEY = 1'b0; steps(2);
      LeftKEY = 1'b1; steps(2);
      LeftKEY = 1'b0; steps(2);
      LeftKEY = 1'b1; steps(12);
      check_int("bounce_no_pulse", left_pulses, 0);

      // Both keys together, twice.
      clear_stats();
      LeftKEY = 1'b0; RightKEY = 1'b0; steps(10);
      LeftKEY = 1'b1; RightKEY = 1'b1; steps(6);
      LeftKEY = 1'b0; RightKEY = 1'b0; steps(10);
      LeftKEY = 1'b1; RightKEY = 1'b1; steps(12);
      check_int("dual_left_count", left_pulses, 2);
      check_int("dual_right_count", right_pulses, 2);
      check("dual_coincident", pair_ok, 1'b1);

      // Reset in the middle of a right press.
      clear_stats();
      RightKEY = 1'b0; steps(3);
      check_int("pre_reset_no_pulse", right_pulses, 0);
      apply_reset(1);
      steps(12);
      check_int("post_reset_edge", first_right_edge, 1 + 2 + D);
      check_int("post_reset_count", right_pulses, 1);
      RightKEY = 1'b1;
      steps(10);

      // The opponent controls: with the macro they drive the right channel,
      // without it they must have no effect.
      clear_stats();
      cpuEnable = 1'b1;
      cpuSpeed  = 4'd15;
      for (int i = 0; i < 1000; i++) begin
         RightKEY = $urandom_range(0, 1);
         step();
      end
`ifdef CPU_OPPONENT_EN
      check("cpu_fast_pulses", right_pulses > 0, 1'b1);
      clear_stats();
      cpuSpeed = 4'd0;
      steps(300);
      check_int("cpu_zero_pulses", right_pulses, 0);
`endif
      cpuEnable = 1'b0;
      RightKEY  = 1'b1;
      steps(12);

      // Randomized bouncing keys, occasional opponent toggles and resets.
      hold_l = 0;
      hold_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold_l == 0) begin
            LeftKEY = $urandom_range(0, 1);
            hold_l  = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 15) : $urandom_range(1, 4);
         end
         if (hold_r == 0) begin
            RightKEY = $urandom_range(0, 1);
            hold_r   = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 15) : $urandom_range(1, 4);
         end
         hold_l--;
         hold_r--;
         if ($urandom_range(0, 199) == 0) begin
            cpuEnable = $urandom_range(0, 1);
            cpuSpeed  = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 599) == 0) apply_reset(1);
         else step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
